mem_access_unit: RTL and testbench

//  Memory-side stage of the multicycle RISC-V core. It consumes the control unit's

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-side stage of the multicycle RISC-V core. It takes the control unit's
// MemRead/MemWrite/IorD/IRWrite strobes, runs one valid/ready transaction on the
// backing memory, and latches read data into IR and MDR. mem_stall holds the
// control FSM in its current state until the access has completed.
//
// Ports
//   clk, reset        core clock (rising edge), asynchronous active-high reset
//   mem_read          read access requested by the control unit
//   mem_write         write access requested by the control unit
//   i_or_d            0: address = pc (fetch), 1: address = alu_out (data)
//   ir_write          also load the read data into IR
//   pc, alu_out       address sources
//   write_data        store data
//   mem_req_*         request channel to memory (valid/ready handshake)
//   mem_resp_*        read response channel (one beat per accepted read)
//   ir, mdr           instruction and memory data registers
//   mem_stall         control unit must hold its current state
//   misaligned        sticky: access with addr[1:0] != 0
//   proto_err         sticky: mem_read and mem_write asserted together
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            i_or_d,
    input  logic            ir_write,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] write_data,
    output logic            mem_req_valid,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    input  logic            mem_req_ready,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] mdr,
    output logic            mem_stall,
    output logic            misaligned,
    output logic            proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_ir;
    logic [XLEN-1:0] r_mdr;
    logic            r_we;
    logic            r_irw;
    logic            r_misaligned;
    logic            r_proto_err;

    logic            w_strobe;
    logic [XLEN-1:0] w_addr;
    logic            w_addr_mis;
    logic            w_start;
    logic            w_resp;
    logic            w_stall;
    logic            w_valid;

    assign w_strobe   = mem_read | mem_write;
    assign w_addr     = i_or_d ? alu_out : pc;
    assign w_addr_mis = (w_addr[1:0] != 2'b00);
    assign w_start    = (r_state == S_IDLE) && w_strobe;
    // Responses are only meaningful while a read is outstanding.
    assign w_resp     = (r_state == S_WAIT) && mem_resp_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    // Stall in the very cycle the strobe appears so the
                    // control unit never advances past an unstarted access.
                    w_stall = 1'b1;
                    w_next  = w_addr_mis ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                w_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next = r_we ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (mem_resp_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // One unstalled cycle lets the control unit advance; strobes
                // still visible here belong to the finished access.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, read-data registers and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_irw        <= 1'b0;
            r_ir         <= '0;
            r_mdr        <= '0;
            r_misaligned <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr  <= w_addr;
                // A simultaneous read and write is performed as a read.
                r_we    <= mem_write & ~mem_read;
                r_wdata <= write_data;
                r_irw   <= ir_write;
                if (w_addr_mis) begin
                    r_misaligned <= 1'b1;
                end
                if (mem_read && mem_write) begin
                    r_proto_err <= 1'b1;
                end
            end
            if (w_resp) begin
                r_mdr <= mem_resp_rdata;
                if (r_irw) begin
                    r_ir <= mem_resp_rdata;
                end
            end
        end
    end

    assign mem_req_valid = w_valid;
    assign mem_req_we    = r_we;
    // Misaligned accesses never reach the bus, so the low bits are always zero
    // on a real request; forcing them keeps the bus address word-aligned.
    assign mem_req_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign mem_req_wdata = r_wdata;
    assign ir            = r_ir;
    assign mdr           = r_mdr;
    assign mem_stall     = w_stall & ~reset;
    assign misaligned    = r_misaligned;
    assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        ir_write;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        mem_stall;
    logic        misaligned;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    // Reference state: what IR/MDR/flags must hold after each completed access
    logic [31:0] m_ir;
    logic [31:0] m_mdr;
    logic        m_mis;
    logic        m_proto;

    mem_access_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .i_or_d         (i_or_d),
        .ir_write       (ir_write),
        .pc             (pc),
        .alu_out        (alu_out),
        .write_data     (write_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .ir             (ir),
        .mdr            (mdr),
        .mem_stall      (mem_stall),
        .misaligned     (misaligned),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".ir"},    ir,         m_ir);
        chk({tag, ".mdr"},   mdr,        m_mdr);
        chk({tag, ".mis"},   misaligned, {31'd0, m_mis});
        chk({tag, ".proto"}, proto_err,  {31'd0, m_proto});
    endtask

    // One complete access. R = cycles ready is held low while valid is up,
    // D = cycles from request acceptance to the read response.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic iord, input logic irw,
                           input logic [31:0] pcv, input logic [31:0] aluv,
                           input logic [31:0] wd, input logic [31:0] rdat,
                           input int R, input int D);
        logic [31:0] ea;
        logic        emis;
        logic        ewe;
        int          exp_st;
        int          stalls;
        int          beats;
        int          reqcyc;
        int          since;
        bit          done;
        ea     = iord ? aluv : pcv;
        emis   = (ea[1:0] != 2'b00);
        ewe    = wr & ~rd;
        // Strobe cycle + (R refused + 1 accepted) request cycles + D wait cycles
        exp_st = emis ? 1 : (rd ? 2 + R + D : 2 + R);

        @(negedge clk);
        mem_read       = rd;
        mem_write      = wr;
        i_or_d         = iord;
        ir_write       = irw;
        pc             = pcv;
        alu_out        = aluv;
        write_data     = wd;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = rdat;
        stalls = 0;
        beats  = 0;
        reqcyc = 0;
        since  = -1;
        done   = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (since >= 0) since++;
            mem_resp_valid = (rd && since == D);
            #1;
            if (!mem_stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req_valid) begin
                    chk({tag, ".addr"},  mem_req_addr,  ea);
                    chk({tag, ".we"},    mem_req_we,    {31'd0, ewe});
                    chk({tag, ".wdata"}, mem_req_wdata, wd);
                    mem_req_ready = (reqcyc >= R);
                    reqcyc++;
                    if (mem_req_ready) begin
                        beats++;
                        since = 0;
                    end
                end else begin
                    mem_req_ready = 1'b0;
                end
                @(negedge clk);
            end
        end
        chk({tag, ".finished"}, {31'd0, done}, 32'd1);
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        if (!emis && rd) begin
            m_mdr = rdat;
            if (irw) m_ir = rdat;
        end
        m_mis   = m_mis | emis;
        m_proto = m_proto | (rd & wr);

        chk({tag, ".stalls"}, stalls, exp_st);
        chk({tag, ".beats"},  beats,  emis ? 0 : 1);
        chk_model(tag);

        @(negedge clk);
        #1;
        chk({tag, ".idle_stall"}, {31'd0, mem_stall},     32'd0);
        chk({tag, ".idle_valid"}, {31'd0, mem_req_valid}, 32'd0);
    endtask

    initial begin
        logic        rd;
        logic        wr;
        logic [31:0] a;
        reset          = 1'b1;
        mem_read       = 1'b1;
        mem_write      = 1'b0;
        i_or_d         = 1'b0;
        ir_write       = 1'b0;
        pc             = 32'h0;
        alu_out        = 32'h0;
        write_data     = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        m_ir = '0; m_mdr = '0; m_mis = 1'b0; m_proto = 1'b0;

        // Reset state, with a strobe present to show stall is forced low
        repeat (2) @(negedge clk);
        #1;
        chk("rst.stall", {31'd0, mem_stall},     32'd0);
        chk("rst.valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst.we",    {31'd0, mem_req_we},    32'd0);
        chk("rst.addr",  mem_req_addr,           32'd0);
        chk("rst.wdata", mem_req_wdata,          32'd0);
        chk_model("rst");
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Directed accesses
        run_txn("fetch", 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0,
                32'h00500093, 0, 1);
        run_txn("store", 1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h2004, 32'hDEADBEEF,
                32'h11111111, 4, 1);
        run_txn("load5", 1'b1, 1'b0, 1'b1, 1'b0, 32'h108, 32'h3000, 32'h0,
                32'hCAFEF00D, 1, 5);
        run_txn("misal", 1'b1, 1'b0, 1'b1, 1'b1, 32'h10C, 32'h2002, 32'h0,
                32'h22222222, 0, 1);
        run_txn("both",  1'b1, 1'b1, 1'b1, 1'b0, 32'h110, 32'h4008, 32'h55AA55AA,
                32'h0BADC0DE, 2, 2);

        // Stray responses while idle must not touch IR/MDR
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = $urandom;
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk_model("stray_idle");

        // Randomized accesses
        for (int i = 0; i < 20; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            a  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_txn("rand", rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom & 32'hFFFF_FFFC, a, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(1, 4));
        end

        // Reset while a read is waiting for its response
        @(negedge clk);
        mem_read      = 1'b1;
        i_or_d        = 1'b0;
        ir_write      = 1'b1;
        pc            = 32'h40;
        mem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rstw.req_valid", {31'd0, mem_req_valid}, 32'd1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("rstw.in_wait", {31'd0, mem_stall}, 32'd1);
        reset = 1'b1;
        #1;
        m_ir = '0; m_mdr = '0; m_mis = 1'b0; m_proto = 1'b0;
        chk("rstw.valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rstw.stall", {31'd0, mem_stall},     32'd0);
        chk_model("rstw");
        @(negedge clk);
        reset          = 1'b0;
        mem_read       = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h12345678;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("rstw.stray_mdr", mdr, 32'd0);
        chk("rstw.idle",      {31'd0, mem_stall}, 32'd0);

        // Normal operation resumes after the reset
        run_txn("refetch", 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0,
                32'h00A00113, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
